// File: rtl/store_buffer.sv
// store_buffer: data-side write buffer between the CPU data port and the
// shared memory data port. CPU stores are queued in a small FIFO and drained
// to memory in cycles where no load owns the port. Loads have priority and
// complete combinationally. A starvation counter forces a drain when the
// buffer stays full behind a stream of loads. A flush request stalls the CPU
// until every queued store has reached memory.
//
// Optional feature macro: STORE_BUFFER_FWD_EN
//   defined   -> loads hitting queued stores return the youngest match's data
//   undefined -> loads hitting queued stores stall while the head drains
module store_buffer #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             cpu_addr,
  input  logic [31:0]             cpu_wdata,
  input  logic                    cpu_write,
  input  logic                    cpu_read,
  output logic [31:0]             cpu_rdata,
  output logic                    cpu_stall,
  input  logic                    flush,
  output logic                    flush_done,
  output logic [31:0]             mem_addr,
  output logic [31:0]             mem_wdata,
  input  logic [31:0]             mem_rdata,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_FLUSH  = 2'd2;

  // Queue storage and control state
  logic [31:0]   addr_q [DEPTH];
  logic [31:0]   addr_d [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   data_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [1:0]    state_q, state_d;

  // Decoded status and arbitration
  logic          full_s;
  logic          empty_s;
  logic          any_req_s;
  logic          flushing_s;
  logic          force_s;
  logic          hit_s;
  logic          hazard_s;
  logic          load_stall_s;
  logic          stall_s;
  logic          load_go_s;
  logic          enq_s;
  logic          drain_s;
  logic [PW-1:0] idx_s;
`ifdef STORE_BUFFER_FWD_EN
  logic [31:0]   hit_data_s;
`endif

  // Occupancy, flush and starvation status decoded from registered state.
  always_comb begin
    full_s     = (count_q == CW'(DEPTH));
    empty_s    = (count_q == {CW{1'b0}});
    any_req_s  = cpu_read | cpu_write;
    // A flush request with work pending stalls the CPU from its first cycle.
    flushing_s = (state_q == ST_FLUSH) | (flush & ~empty_s);
    force_s    = (starve_q == SW'(STARVE_LIMIT));
  end

  // Address match of the current CPU address against all occupied entries;
  // walking oldest to youngest leaves the youngest match in hit_data_s.
  always_comb begin
    hit_s = 1'b0;
    idx_s = {PW{1'b0}};
`ifdef STORE_BUFFER_FWD_EN
    hit_data_s = 32'd0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      idx_s = head_q + PW'(i);
      if ((CW'(i) < count_q) && (addr_q[idx_s] == cpu_addr)) begin
        hit_s = 1'b1;
`ifdef STORE_BUFFER_FWD_EN
        hit_data_s = data_q[idx_s];
`endif
      end else begin
        hit_s = hit_s;
      end
    end
  end

  // Port arbitration: loads own the memory port unless stalled; otherwise the
  // head entry drains. Everything is held off while reset is asserted.
  always_comb begin
`ifdef STORE_BUFFER_FWD_EN
    hazard_s = 1'b0;
`else
    // Without forwarding a load hitting a queued store must wait for it.
    hazard_s = cpu_read & hit_s;
`endif
    // A store blocked by a full buffer does not block a load in the same cycle.
    load_stall_s = flushing_s | force_s | hazard_s;
    if (!rst) begin
      stall_s   = 1'b0;
      load_go_s = 1'b0;
      enq_s     = 1'b0;
      drain_s   = 1'b0;
    end else begin
      stall_s   = (cpu_write & full_s) | (any_req_s & flushing_s) | force_s | hazard_s;
      load_go_s = cpu_read & ~load_stall_s;
      enq_s     = cpu_write & ~stall_s;
      drain_s   = ~empty_s & ~load_go_s;
    end
  end

  // Drive the memory port and CPU return path from the arbitration result.
  always_comb begin
    mem_read   = load_go_s;
    mem_write  = drain_s;
    cpu_stall  = stall_s;
    flush_done = empty_s & (state_q != ST_FLUSH);
    count      = count_q;
    if (load_go_s) begin
      mem_addr  = cpu_addr;
      mem_wdata = 32'd0;
    end else if (drain_s) begin
      mem_addr  = addr_q[head_q];
      mem_wdata = data_q[head_q];
    end else begin
      mem_addr  = 32'd0;
      mem_wdata = 32'd0;
    end
    if (load_go_s) begin
`ifdef STORE_BUFFER_FWD_EN
      cpu_rdata = hit_s ? hit_data_s : mem_rdata;
`else
      cpu_rdata = mem_rdata;
`endif
    end else begin
      cpu_rdata = 32'd0;
    end
  end

  // Next-state for the FIFO storage, pointers and occupancy.
  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    if (enq_s) begin
      addr_d[tail_q] = cpu_addr;
      data_d[tail_q] = cpu_wdata;
      tail_d         = tail_q + PW'(1);
    end else begin
      tail_d = tail_q;
    end
    if (drain_s) begin
      head_d = head_q + PW'(1);
    end else begin
      head_d = head_q;
    end
    case ({enq_s, drain_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Starvation counter: consecutive full cycles where a load blocked the drain.
  always_comb begin
    if (drain_s) begin
      starve_d = {SW{1'b0}};
    end else if (full_s & load_go_s) begin
      starve_d = force_s ? starve_q : (starve_q + SW'(1));
    end else begin
      starve_d = {SW{1'b0}};
    end
  end

  // Control FSM: IDLE when empty, ACTIVE when occupied, FLUSH until empty.
  always_comb begin
    case (state_q)
      ST_IDLE, ST_ACTIVE: begin
        if (flush) begin
          state_d = (count_d == {CW{1'b0}}) ? ST_IDLE : ST_FLUSH;
        end else begin
          state_d = (count_d == {CW{1'b0}}) ? ST_IDLE : ST_ACTIVE;
        end
      end
      ST_FLUSH: begin
        state_d = (count_d == {CW{1'b0}}) ? ST_IDLE : ST_FLUSH;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset discards any queued stores.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= 32'd0;
        data_q[i] <= 32'd0;
      end
      head_q   <= {PW{1'b0}};
      tail_q   <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      starve_q <= {SW{1'b0}};
      state_q  <= ST_IDLE;
    end else begin
      addr_q   <= addr_d;
      data_q   <= data_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      state_q  <= state_d;
    end
  end

endmodule
